// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate bus: one-hot grant/oe, a forced all-off turnaround between owners,
// and preemption of owners past MAX_HOLD. Request to grant takes 1 cycle and request to oe takes 2; a requester waits by holding req.
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int IDXW     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    oe,
  output logic [IDXW-1:0] owner,
  output logic            busy,
  output logic            preempt
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

  state_t          state, state_d;
  logic [IDXW-1:0] rr, rr_d, owner_d, pick, cand;
  logic            pick_vld;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic            preempt_d, busy_d;
  logic [N-1:0]    grant_d, oe_d, owner_hot, owner_hot_d;
  logic            others;

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] i);
    if (int'(i) == N - 1) return '0;
    return i + 1'b1;
  endfunction

  assign owner_hot   = N'(1) << owner;
  assign owner_hot_d = N'(1) << owner_d;
  assign others      = |(req & ~owner_hot);

  // Descending scan so the last hit, i.e. the one closest to rr, wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDXW'((int'(rr) + i) % N);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr       <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
      grant    <= '0;
      oe       <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      rr       <= rr_d;
      hold_cnt <= hold_d;
      preempt  <= preempt_d;
      grant    <= grant_d;
      oe       <= oe_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d   = state;
    owner_d   = owner;
    rr_d      = rr;
    hold_d    = hold_cnt;
    preempt_d = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_d = TURN;
          owner_d = pick;
        end
      end
      TURN: begin
        if (req[owner]) begin
          state_d = OWN;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!req[owner]) begin
          state_d = IDLE;
          rr_d    = wrap_inc(owner);
        end else if (MAX_HOLD != 0 && hold_cnt >= HOLD_LAST && others) begin
          // Saturated counter keeps this armed, so a late competitor preempts at once.
          state_d   = IDLE;
          preempt_d = 1'b1;
          rr_d      = wrap_inc(owner);
        end else if (hold_cnt != HOLD_MAX) begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = (state_d != IDLE) ? owner_hot_d : '0;
    oe_d    = (state_d == OWN)  ? owner_hot_d : '0;
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N=4, MAX_HOLD=4): vector table plus round-robin, no-competitor and reset sequences.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant, oe;
  logic [1:0] owner;
  logic       busy, preempt;

  int tests = 0;
  int fails = 0;

  tristate_bus_arbiter #(.N(4), .IDXW(2), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .oe(oe),
    .owner(owner), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [3:0] o,
                     input logic [1:0] ow, input logic b, input logic p);
    vec_t v;
    v.rst = r; v.req = rq; v.grant = g; v.oe = o; v.owner = ow; v.busy = b; v.preempt = p;
    vecs.push_back(v);
  endtask

  // Drive inputs, let one edge sample them, then compare the registered outputs.
  task automatic apply(input string nm, input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [3:0] o, input logic [1:0] ow, input logic b, input logic p);
    rst = r;
    req = rq;
    @(posedge clk);
    #1;
    tests++;
    if (grant !== g || oe !== o || owner !== ow || busy !== b || preempt !== p) begin
      fails++;
      $display("FAIL %s: got grant=%b oe=%b owner=%0d busy=%b preempt=%b, want grant=%b oe=%b owner=%0d busy=%b preempt=%b",
               nm, grant, oe, owner, busy, preempt, g, o, ow, b, p);
    end
  endtask

  logic [3:0] prev_oe = '0;
  always @(negedge clk) begin
    tests++;
    if (!$onehot0(oe) || !$onehot0(grant) || (oe & ~grant) != 4'b0 ||
        (prev_oe != 4'b0 && oe != 4'b0 && oe != prev_oe)) begin
      fails++;
      $display("FAIL invariant: got oe=%b grant=%b prev_oe=%b, want one-hot oe within grant and no direct handoff",
               oe, grant, prev_oe);
    end
    prev_oe = oe;
  end

  initial begin
    // Reset and single requester
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // Abort in TURN
    add(0, 4'b1000, 4'b1000, 4'b0000, 3, 1, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 3, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 3, 0, 0);
    // Preemption after 4 OWN cycles; rr=1 wraps the search round to 0
    add(0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0101, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0101, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0101, 4'b0001, 4'b0001, 0, 1, 0);
    add(0, 4'b0101, 4'b0000, 4'b0000, 0, 0, 1);
    add(0, 4'b0101, 4'b0100, 4'b0000, 2, 1, 0);
    add(0, 4'b0101, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 2, 0, 0);
    // Release coinciding with the hold limit is a plain release
    add(0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0);
    add(0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 0);
    add(0, 4'b1000, 4'b1000, 4'b0000, 3, 1, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 3, 0, 0);

    foreach (vecs[i]) begin
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].grant, vecs[i].oe,
            vecs[i].owner, vecs[i].busy, vecs[i].preempt);
    end

    // Round-robin with all requesters; each releases after 3 OWN cycles
    apply("rr_reset", 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] o;
      logic [3:0] hot;
      o   = 2'(k % 4);
      hot = 4'b0001 << o;
      apply($sformatf("rr%0d_turn", k), 0, 4'b1111, hot, 4'b0000, o, 1, 0);
      for (int c = 0; c < 3; c++)
        apply($sformatf("rr%0d_own%0d", k, c), 0, 4'b1111, hot, hot, o, 1, 0);
      apply($sformatf("rr%0d_rel", k), 0, 4'b1111 & ~hot, 4'b0000, 4'b0000, o, 0, 0);
    end

    // Lone owner keeps the bus past the limit; a late competitor preempts immediately
    apply("solo_turn", 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 0);
    for (int c = 0; c < 20; c++)
      apply($sformatf("solo_own%0d", c), 0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0);
    apply("late_preempt", 0, 4'b1010, 4'b0000, 4'b0000, 1, 0, 1);
    apply("late_turn",    0, 4'b1010, 4'b1000, 4'b0000, 3, 1, 0);
    apply("late_own",     0, 4'b1010, 4'b1000, 4'b1000, 3, 1, 0);

    // Reset mid-ownership clears oe at once and restarts the search at index 0
    apply("mid_reset",    1, 4'b1010, 4'b0000, 4'b0000, 0, 0, 0);
    apply("post_turn",    0, 4'b1010, 4'b0010, 4'b0000, 1, 1, 0);
    apply("post_own",     0, 4'b1010, 4'b0010, 4'b0010, 1, 1, 0);

    req = '0;
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
